// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the data memory between the processor (port 0)
// and a secondary master (port 1) with round-robin request/ack arbitration.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   pN_req/we/addr/wdata request, direction, block address, write block
//   pN_ack, pN_rdata    one-cycle completion pulse, held read block
//   mem_addr/mem_wdata  latched address/write block towards memory
//   mem_read/mem_write  single-cycle strobes, mutually exclusive
//   mem_rdata           read block, valid MEM_LAT cycles after the strobe
//   busy, owner         arbiter active, last granted port
module data_mem_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 256,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rd0_q, rd0_d;
    logic [DATA_W-1:0]   rd1_q, rd1_d;
    logic                gnt;

    // Under contention the port that did not win last time is served,
    // so continuous requesters alternate strictly.
    always_comb begin
        gnt = 1'b0;
        if (p0_req && p1_req) begin
            gnt = ~last_q;
        end else if (p1_req) begin
            gnt = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        unique case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    owner_d = gnt;
                    last_d  = gnt;
                    we_d    = gnt ? p1_we    : p0_we;
                    addr_d  = gnt ? p1_addr  : p0_addr;
                    wdata_d = gnt ? p1_wdata : p0_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Memory data is valid on the edge where the count is 1.
                if (cnt_q == 4'd1) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        if (owner_q) begin
                            rd1_d = mem_rdata;
                        end else begin
                            rd0_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    // Strobes decode straight from state so a reset drops them at once.
    assign mem_read  = (state_q == S_ISSUE) && !we_q;
    assign mem_write = (state_q == S_ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign p0_ack    = (state_q == S_DONE) && !owner_q;
    assign p1_ack    = (state_q == S_DONE) && owner_q;
    assign p0_rdata  = rd0_q;
    assign p1_rdata  = rd1_q;
    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized bench for data_mem_arbiter with a
// transaction-level schedule model and behavioural memory devices.
module tb_data_mem_arbiter;

    localparam int AW  = 11;
    localparam int DW  = 256;
    localparam int LAT = 2;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read, mem_write;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy, owner;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] dev_mem [int];
    logic [DW-1:0] ref_mem [int];

    int            m_last = 1;
    logic          m_owner = 1'b0;
    logic [DW-1:0] m_rd [2];

    txn_t plan [2][8];
    int   plan_n [2];
    int   plan_off [2];
    bit   plan_scr;

    always #5 clock = ~clock;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++)
            v[i*32 +: 32] = 32'(a) * 32'h9E3779B1 + 32'(i);
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd_blk();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic txn_t rnd_txn(input int amax);
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = AW'($urandom_range(0, amax));
        t.wdata = rnd_blk();
        return t;
    endfunction

    // Memory device: writes land on the strobe edge; read data is valid
    // for one cycle, LAT cycles after the strobe cycle, junk otherwise.
    always @(posedge clock) begin : dev_main
        int a;
        if (mem_write) dev_mem[int'(mem_addr)] = mem_wdata;
        if (mem_read) begin
            a = int'(mem_addr);
            repeat (LAT - 1) @(posedge clock);
            #1 mem_rdata = dev_mem.exists(a) ? dev_mem[a] : init_val(a);
            @(posedge clock);
            #1 mem_rdata = rnd_blk();
        end
    end

    // Extra instances with other latencies, port 0 reads only.
    logic [1:0]         a_req = 2'b00;
    logic [1:0][AW-1:0] a_addr = '0;
    logic [1:0]         a_ack, a_p1ack, a_busy, a_own, a_rd, a_wr;

    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int L = (g == 0) ? 1 : 4;
        logic [DW-1:0] rdata, p1rd, mwd;
        logic [DW-1:0] mrd = '0;
        logic [AW-1:0] mad;
        data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) u (
            .clock(clock), .reset(reset),
            .p0_req(a_req[g]), .p0_we(1'b0), .p0_addr(a_addr[g]),
            .p0_wdata('0), .p0_ack(a_ack[g]), .p0_rdata(rdata),
            .p1_req(1'b0), .p1_we(1'b0), .p1_addr('0),
            .p1_wdata('0), .p1_ack(a_p1ack[g]), .p1_rdata(p1rd),
            .mem_addr(mad), .mem_wdata(mwd),
            .mem_read(a_rd[g]), .mem_write(a_wr[g]),
            .mem_rdata(mrd), .busy(a_busy[g]), .owner(a_own[g])
        );
        always @(posedge clock) begin : dev
            int a;
            if (a_rd[g]) begin
                a = int'(mad);
                repeat (L - 1) @(posedge clock);
                #1 mrd = init_val(a);
                @(posedge clock);
                #1 mrd = rnd_blk();
            end
        end
    end

    task automatic drive_port(input int p, input bit rq, input txn_t t);
        if (p == 0) begin
            p0_req = rq; p0_we = t.we; p0_addr = t.addr; p0_wdata = t.wdata;
        end else begin
            p1_req = rq; p1_we = t.we; p1_addr = t.addr; p1_wdata = t.wdata;
        end
    endtask

    // Transaction-level run: the model works out every grant edge from
    // request arrival times and round-robin, then each cycle is checked.
    task automatic test_run(input string name);
        int   gp[16], ge[16], gk[16];
        int   ag[2][8], pres[2][8];
        int   nxt[2], cur[2];
        bit   pend[2];
        int   ng, t, w, last_c, gi, big;
        logic eb, er, ew, eo;
        logic [1:0] ea;
        logic [5:0] exp_v, obs_v;
        txn_t tx;
        ng = 0;
        for (int p = 0; p < 2; p++) begin
            nxt[p] = 0;
            cur[p] = -1;
            if (plan_n[p] > 0) pres[p][0] = plan_off[p];
        end
        t = 1;
        while (nxt[0] < plan_n[0] || nxt[1] < plan_n[1]) begin
            for (int p = 0; p < 2; p++)
                pend[p] = nxt[p] < plan_n[p] && pres[p][nxt[p]] < t;
            if (!pend[0] && !pend[1]) begin
                big = 1 << 20;
                for (int p = 0; p < 2; p++)
                    if (nxt[p] < plan_n[p] && pres[p][nxt[p]] + 1 < big)
                        big = pres[p][nxt[p]] + 1;
                t = big;
                continue;
            end
            if (pend[0] && pend[1]) w = (m_last == 0) ? 1 : 0;
            else w = pend[1] ? 1 : 0;
            gp[ng] = w; ge[ng] = t; gk[ng] = nxt[w]; ng++;
            ag[w][nxt[w]] = t;
            m_last = w;
            nxt[w]++;
            if (nxt[w] < plan_n[w]) pres[w][nxt[w]] = t + LAT + 1;
            t = t + LAT + 3;
        end
        last_c = (ng > 0) ? ge[ng-1] + LAT + 3 : 2;
        for (int p = 0; p < 2; p++) nxt[p] = 0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        for (int c = 0; c <= last_c; c++) begin
            if (c > 0) begin
                @(posedge clock);
                #1;
                eb = 1'b0; er = 1'b0; ew = 1'b0; ea = 2'b00;
                eo = m_owner; gi = -1;
                for (int g = 0; g < ng; g++) begin
                    if (ge[g] <= c) eo = gp[g][0];
                    if (c >= ge[g] && c <= ge[g] + LAT + 1) eb = 1'b1;
                    if (c == ge[g]) gi = g;
                    if (c == ge[g] + LAT + 1) begin
                        ea[gp[g]] = 1'b1;
                        tx = plan[gp[g]][gk[g]];
                        if (tx.we) ref_mem[int'(tx.addr)] = tx.wdata;
                        else m_rd[gp[g]] = ref_rd(int'(tx.addr));
                    end
                end
                if (gi >= 0) begin
                    tx = plan[gp[gi]][gk[gi]];
                    er = !tx.we;
                    ew = tx.we;
                    n_cmp++;
                    if (mem_addr !== tx.addr || mem_wdata !== tx.wdata) begin
                        n_bad++;
                        $display("FAIL %s c=%0d mem_addr got=%h want=%h wdata got=%h want=%h",
                                 name, c, mem_addr, tx.addr, mem_wdata, tx.wdata);
                    end
                end
                exp_v = {eb, er, ew, ea, eo};
                obs_v = {busy, mem_read, mem_write, p1_ack, p0_ack, owner};
                n_cmp++;
                if (obs_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL %s c=%0d busy/rd/wr/ack1/ack0/own got=%b want=%b",
                             name, c, obs_v, exp_v);
                end
                n_cmp++;
                if (p0_rdata !== m_rd[0] || p1_rdata !== m_rd[1]) begin
                    n_bad++;
                    $display("FAIL %s c=%0d rdata p0 got=%h want=%h p1 got=%h want=%h",
                             name, c, p0_rdata, m_rd[0], p1_rdata, m_rd[1]);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (cur[p] >= 0 && c == ag[p][cur[p]] + LAT + 1) begin
                    drive_port(p, 1'b0, plan[p][cur[p]]);
                    cur[p] = -1;
                end
                if (nxt[p] < plan_n[p] && pres[p][nxt[p]] == c) begin
                    drive_port(p, 1'b1, plan[p][nxt[p]]);
                    cur[p] = nxt[p];
                    nxt[p]++;
                end else if (plan_scr && cur[p] >= 0 && c >= ag[p][cur[p]]) begin
                    drive_port(p, 1'b1, rnd_txn(2047));
                end
            end
        end
        if (ng > 0) m_owner = gp[ng-1][0];
    endtask

    task automatic test_reset();
        logic [DW-1:0] z;
        z = '0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({busy, mem_read, mem_write, p0_ack, p1_ack, owner} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctl got=%b want=000000",
                     {busy, mem_read, mem_write, p0_ack, p1_ack, owner});
        end
        n_cmp++;
        if (mem_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_mem_addr got=%h want=0", mem_addr);
        end
        n_cmp++;
        if (mem_wdata !== z) begin
            n_bad++;
            $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata);
        end
        n_cmp++;
        if (p0_rdata !== z || p1_rdata !== z) begin
            n_bad++;
            $display("FAIL reset_rdata p0=%h p1=%h want=0", p0_rdata, p1_rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_p0_read();
        logic [DW-1:0] a5;
        for (int i = 0; i < DW / 8; i++) a5[i*8 +: 8] = 8'hA5;
        dev_mem[5] = a5;
        ref_mem[5] = a5;
        plan_n = '{1, 0}; plan_off = '{0, 0}; plan_scr = 1'b0;
        plan[0][0] = '{1'b0, 11'h005, rnd_blk()};
        test_run("p0_read");
        n_cmp++;
        if (p0_rdata !== a5) begin
            n_bad++;
            $display("FAIL p0_read_data got=%h want=%h", p0_rdata, a5);
        end
    endtask

    task automatic test_p1_write();
        logic [DW-1:0] w;
        w = DW'(32'h1234);
        plan_n = '{0, 1}; plan_off = '{0, 0}; plan_scr = 1'b0;
        plan[1][0] = '{1'b1, 11'h7FF, w};
        test_run("p1_write");
        n_cmp++;
        if (p1_rdata !== '0 || dev_mem[2047] !== w) begin
            n_bad++;
            $display("FAIL p1_write p1_rdata got=%h want=0 mem got=%h want=%h",
                     p1_rdata, dev_mem[2047], w);
        end
    endtask

    task automatic test_contention();
        plan_n = '{2, 2}; plan_off = '{0, 0}; plan_scr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            plan[0][k] = rnd_txn(15);
            plan[1][k] = rnd_txn(15);
        end
        test_run("contention");
    endtask

    task automatic test_late_request();
        plan_n = '{1, 1}; plan_off = '{0, 2}; plan_scr = 1'b0;
        plan[0][0] = rnd_txn(15);
        plan[1][0] = rnd_txn(15);
        test_run("late_req");
    endtask

    task automatic test_reset_midop();
        txn_t tx;
        tx = rnd_txn(15);
        tx.we = 1'b0;
        drive_port(0, 1'b1, tx);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midop_busy_before got=%b want=1", busy);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, mem_read, mem_write, p0_ack, p1_ack, owner} !== 6'b0) begin
            n_bad++;
            $display("FAIL midop_async got=%b want=000000",
                     {busy, mem_read, mem_write, p0_ack, p1_ack, owner});
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            n_cmp++;
            if ({busy, p0_ack, mem_read} !== 3'b0) begin
                n_bad++;
                $display("FAIL midop_hold got=%b want=000", {busy, p0_ack, mem_read});
            end
        end
        reset = 1'b1;
        m_last = 1;
        m_owner = 1'b0;
        m_rd[0] = '0;
        m_rd[1] = '0;
        plan_n = '{1, 0}; plan_off = '{0, 0}; plan_scr = 1'b0;
        plan[0][0] = tx;
        test_run("midop_reserve");
    endtask

    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            plan_n[0] = $urandom_range(0, 3);
            plan_n[1] = $urandom_range(0, 3);
            if (plan_n[0] + plan_n[1] == 0) plan_n[0] = 1;
            plan_off[0] = $urandom_range(0, 4);
            plan_off[1] = $urandom_range(0, 4);
            plan_scr = 1'b1;
            for (int p = 0; p < 2; p++)
                for (int k = 0; k < plan_n[p]; k++) plan[p][k] = rnd_txn(15);
            test_run("random");
        end
    endtask

    task automatic test_latency_variants();
        int            ack_c[2], ack_n[2], want;
        logic [DW-1:0] got[2];
        logic [AW-1:0] ad[2];
        for (int trial = 0; trial < 3; trial++) begin
            for (int g = 0; g < 2; g++) begin
                ad[g] = AW'($urandom_range(0, 2047));
                ack_c[g] = -1;
                ack_n[g] = 0;
                got[g] = '0;
            end
            a_addr[0] = ad[0];
            a_addr[1] = ad[1];
            a_req = 2'b11;
            for (int c = 1; c <= 10; c++) begin
                @(posedge clock);
                #1;
                if (a_ack[0]) got[0] = g_lat[0].rdata;
                if (a_ack[1]) got[1] = g_lat[1].rdata;
                for (int g = 0; g < 2; g++) begin
                    if (a_ack[g]) begin
                        ack_n[g]++;
                        if (ack_c[g] < 0) ack_c[g] = c;
                        a_req[g] = 1'b0;
                    end
                end
            end
            for (int g = 0; g < 2; g++) begin
                want = (g == 0) ? 3 : 6;
                n_cmp++;
                if (ack_c[g] != want || ack_n[g] != 1) begin
                    n_bad++;
                    $display("FAIL lat_ack inst=%0d edge got=%0d want=%0d pulses got=%0d want=1",
                             g, ack_c[g], want, ack_n[g]);
                end
                n_cmp++;
                if (got[g] !== init_val(int'(ad[g]))) begin
                    n_bad++;
                    $display("FAIL lat_data inst=%0d got=%h want=%h",
                             g, got[g], init_val(int'(ad[g])));
                end
            end
            n_cmp++;
            if (a_busy !== 2'b00) begin
                n_bad++;
                $display("FAIL lat_idle got=%b want=00", a_busy);
            end
        end
    endtask

    initial begin
        m_rd[0] = '0;
        m_rd[1] = '0;
        test_reset();
        test_p0_read();
        test_p1_write();
        test_contention();
        test_late_request();
        test_reset_midop();
        test_random(25);
        test_latency_variants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
